cpu_imm_gen_pipe: RTL

- Pipelined, parametrised successor to the combinational offset generator used by the decoder.
- Takes the full 32-bit RISC-V instruction and classifies the format itself from the opcode; no external type flags.
- Produces the XLEN-wide sign-extended immediate, a one-hot format vector and an illegal flag, all behind a valid/ready handshake.
- Sits between fetch and decode/execute, carrying a sideband tag (typically the PC) alongside each instruction.

---
 rtl/cpu_imm_gen_pipe.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// cpu_imm_gen_pipe : pipelined RISC-V immediate generator with a skid buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter bit ZICSR = 1'b1,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [6:0] c_op_lui     = 7'b0110111;
  localparam logic [6:0] c_op_auipc   = 7'b0010111;
  localparam logic [6:0] c_op_jal     = 7'b1101111;
  localparam logic [6:0] c_op_jalr    = 7'b1100111;
  localparam logic [6:0] c_op_load    = 7'b0000011;
  localparam logic [6:0] c_op_opimm   = 7'b0010011;
  localparam logic [6:0] c_op_miscmem = 7'b0001111;
  localparam logic [6:0] c_op_system  = 7'b1110011;
  localparam logic [6:0] c_op_opimm32 = 7'b0011011;
  localparam logic [6:0] c_op_branch  = 7'b1100011;
  localparam logic [6:0] c_op_store   = 7'b0100011;
  localparam logic [6:0] c_op_op      = 7'b0110011;
  localparam logic [6:0] c_op_op32    = 7'b0111011;

  localparam logic [5:0] c_fmt_r = 6'b100000;
  localparam logic [5:0] c_fmt_i = 6'b010000;
  localparam logic [5:0] c_fmt_s = 6'b001000;
  localparam logic [5:0] c_fmt_b = 6'b000100;
  localparam logic [5:0] c_fmt_u = 6'b000010;
  localparam logic [5:0] c_fmt_j = 6'b000001;

  localparam bit c_rv64 = (XLEN == 64);

  logic [31:0]      w_imm32;
  logic [XLEN-1:0]  w_dec_imm;
  logic [5:0]       w_dec_fmt;
  logic             w_dec_ill;
  logic             w_s;

  always_comb begin
    w_s       = in_inst[31];
    w_imm32   = 32'd0;
    w_dec_fmt = 6'd0;
    w_dec_ill = 1'b0;
    case (in_inst[6:0])
      c_op_lui, c_op_auipc: begin
        w_dec_fmt = c_fmt_u;
        w_imm32   = {in_inst[31:12], 12'd0};
      end
      c_op_jal: begin
        w_dec_fmt = c_fmt_j;
        w_imm32   = {{11{w_s}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      c_op_jalr, c_op_load, c_op_opimm, c_op_miscmem: begin
        w_dec_fmt = c_fmt_i;
        w_imm32   = {{20{w_s}}, in_inst[31:20]};
      end
      c_op_system: begin
        w_dec_fmt = c_fmt_i;
        // CSR-immediate forms carry a 5-bit unsigned zimm in the rs1 field
        if (ZICSR && in_inst[14]) w_imm32 = {27'd0, in_inst[19:15]};
        else                      w_imm32 = {{20{w_s}}, in_inst[31:20]};
      end
      c_op_opimm32: begin
        if (c_rv64) begin
          w_dec_fmt = c_fmt_i;
          w_imm32   = {{20{w_s}}, in_inst[31:20]};
        end else begin
          w_dec_ill = 1'b1;
        end
      end
      c_op_branch: begin
        w_dec_fmt = c_fmt_b;
        w_imm32   = {{19{w_s}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      c_op_store: begin
        w_dec_fmt = c_fmt_s;
        w_imm32   = {{20{w_s}}, in_inst[31:25], in_inst[11:7]};
      end
      c_op_op: w_dec_fmt = c_fmt_r;
      c_op_op32: begin
        if (c_rv64) w_dec_fmt = c_fmt_r;
        else        w_dec_ill = 1'b1;
      end
      default: w_dec_ill = 1'b1;
    endcase
    w_dec_imm = XLEN'($signed(w_imm32));
  end

  logic             out_valid_q,   out_valid_d;
  logic [XLEN-1:0]  out_imm_q,     out_imm_d;
  logic [5:0]       out_fmt_q,     out_fmt_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;
  logic             skid_full_q,   skid_full_d;
  logic [XLEN-1:0]  skid_imm_q,    skid_imm_d;
  logic [5:0]       skid_fmt_q,    skid_fmt_d;
  logic             skid_ill_q,    skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q,    skid_tag_d;
  logic             in_ready_q,    in_ready_d;

  logic w_accept;
  logic w_out_free;

  always_comb begin
    w_accept      = in_valid & in_ready_q;
    w_out_free    = ~out_valid_q | out_ready;
    out_valid_d   = out_valid_q;
    out_imm_d     = out_imm_q;
    out_fmt_d     = out_fmt_q;
    out_illegal_d = out_illegal_q;
    out_tag_d     = out_tag_q;
    skid_full_d   = skid_full_q;
    skid_imm_d    = skid_imm_q;
    skid_fmt_d    = skid_fmt_q;
    skid_ill_d    = skid_ill_q;
    skid_tag_d    = skid_tag_q;
    if (w_out_free) begin
      // A full skid blocks new input, so it is always the older entry
      if (skid_full_q) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_ill_q;
        out_tag_d     = skid_tag_q;
        skid_full_d   = 1'b0;
      end else if (w_accept) begin
        out_valid_d   = 1'b1;
        out_imm_d     = w_dec_imm;
        out_fmt_d     = w_dec_fmt;
        out_illegal_d = w_dec_ill;
        out_tag_d     = in_tag;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (w_accept) begin
      skid_full_d = 1'b1;
      skid_imm_d  = w_dec_imm;
      skid_fmt_d  = w_dec_fmt;
      skid_ill_d  = w_dec_ill;
      skid_tag_d  = in_tag;
    end
    in_ready_d = ~skid_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= '0;
      out_illegal_q <= 1'b0;
      out_tag_q     <= '0;
      skid_full_q   <= 1'b0;
      skid_imm_q    <= '0;
      skid_fmt_q    <= '0;
      skid_ill_q    <= 1'b0;
      skid_tag_q    <= '0;
      in_ready_q    <= 1'b1;
    end else begin
      out_valid_q   <= out_valid_d;
      out_imm_q     <= out_imm_d;
      out_fmt_q     <= out_fmt_d;
      out_illegal_q <= out_illegal_d;
      out_tag_q     <= out_tag_d;
      skid_full_q   <= skid_full_d;
      skid_imm_q    <= skid_imm_d;
      skid_fmt_q    <= skid_fmt_d;
      skid_ill_q    <= skid_ill_d;
      skid_tag_q    <= skid_tag_d;
      in_ready_q    <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign out_tag     = out_tag_q;

endmodule

`default_nettype wire
